// File: rtl/spi_byte_engine_if.sv
// CPU register-access strobes and SPI pins for spi_byte_engine.
// The engine uses the slave modport; the CPU/device side uses master.
interface spi_byte_engine_if;
  logic       cs;
  logic       we;
  logic [1:0] addr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       sclk;
  logic       mosi;
  logic       miso;
  logic       busy;

  modport master (output cs, we, addr, din, miso, input dout, sclk, mosi, busy);
  modport slave  (input cs, we, addr, din, miso, output dout, sclk, mosi, busy);
endinterface

// File: rtl/spi_byte_engine.sv
// Mode-0, MSB-first SPI byte shifter with DATA/STATUS/CMD/DIV registers.
// Define SPI_TXBUF_EN to add a one-byte TX holding register for back-to-back bytes.
//
// state | meaning
// IDLE  | no transfer, SCLK low, MOSI high
// LOW   | SCLK low phase of current bit (DIV+1 cycles)
// HIGH  | SCLK high phase of current bit (DIV+1 cycles)
// FIN   | one cycle: publish RX, set DONE, chain or return to IDLE
module spi_byte_engine #(
  parameter logic [7:0] DIV_RESET = 8'd59
) (
  input logic              mhz48_i,
  input logic              res_i,
  spi_byte_engine_if.slave bus
);

`ifdef SPI_TXBUF_EN
  localparam bit TXBUF = 1'b1;
`else
  localparam bit TXBUF = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2, FIN = 2'd3} state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] sh_q, sh_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] div_q, div_d;
  logic [2:0] bit_q, bit_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       ovr_q, ovr_d;
  logic       txfull_q, txfull_d;

  logic       wr_data, rd_data, wr_cmd, wr_div;
  logic       phase_end, start_din, start_hold, load;
  logic [7:0] load_val;
  logic       busy;
  logic [7:0] dout;

  always_ff @(posedge mhz48_i) begin
    if (res_i) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      tx_q     <= 8'd0;
      sh_q     <= 8'd0;
      rx_q     <= 8'hFF;
      hold_q   <= 8'd0;
      div_q    <= DIV_RESET;
      bit_q    <= 3'd0;
      sclk_q   <= 1'b0;
      mosi_q   <= 1'b1;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      txfull_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      sh_q     <= sh_d;
      rx_q     <= rx_d;
      hold_q   <= hold_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      sclk_q   <= sclk_d;
      mosi_q   <= mosi_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
      txfull_q <= txfull_d;
    end
  end

  always_comb begin
    wr_data    = bus.cs && bus.we && (bus.addr == 2'd0);
    rd_data    = bus.cs && !bus.we && (bus.addr == 2'd0);
    wr_cmd     = bus.cs && bus.we && (bus.addr == 2'd1);
    wr_div     = bus.cs && bus.we && (bus.addr == 2'd2);
    phase_end  = (cnt_q == 8'd0);
    // A write landing in FIN with an empty buffer chains directly instead of being stranded.
    start_hold = TXBUF && (state_q == FIN) && txfull_q;
    start_din  = wr_data && ((state_q == IDLE) ||
                             (TXBUF && (state_q == FIN) && !txfull_q));
    load       = start_hold || start_din;
    load_val   = start_hold ? hold_q : bus.din;

    state_d  = state_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    sh_d     = sh_q;
    rx_d     = rx_q;
    hold_d   = hold_q;
    div_d    = div_q;
    bit_d    = bit_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    txfull_d = txfull_q;

    case (state_q)
      LOW: begin
        if (phase_end) begin
          sclk_d  = 1'b1;
          sh_d    = {sh_q[6:0], bus.miso};
          cnt_d   = div_q;
          state_d = HIGH;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          sclk_d = 1'b0;
          cnt_d  = div_q;
          if (bit_q != 3'd0) begin
            bit_d   = bit_q - 3'd1;
            tx_d    = {tx_q[6:0], 1'b0};
            mosi_d  = tx_q[6];
            state_d = LOW;
          end else begin
            state_d = FIN;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      FIN: begin
        rx_d    = sh_q;
        mosi_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d = LOW;
      tx_d    = load_val;
      mosi_d  = load_val[7];
      bit_d   = 3'd7;
      cnt_d   = div_q;
      sclk_d  = 1'b0;
      if (start_hold) txfull_d = 1'b0;
    end

    if (wr_data && !start_din) begin
      if (TXBUF && !txfull_q) begin
        hold_d   = bus.din;
        txfull_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (wr_cmd && bus.din[6]) done_d = 1'b0;
    if (wr_cmd && bus.din[5]) ovr_d  = 1'b0;
    if (rd_data)              done_d = 1'b0;
    if (wr_div && (state_q == IDLE)) div_d = bus.din;
    // Completion beats a same-cycle DATA read clear.
    if (state_q == FIN) done_d = 1'b1;
  end

  always_comb begin
    busy = (state_q != IDLE);
    case (bus.addr)
      2'd0:    dout = rx_q;
      2'd1:    dout = {busy, done_q, ovr_q, txfull_q, 4'b0000};
      2'd2:    dout = div_q;
      default: dout = 8'h00;
    endcase
  end

  assign bus.busy = busy;
  assign bus.dout = dout;
  assign bus.sclk = sclk_q;
  assign bus.mosi = mosi_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine: register map, bit timing, overrun and reset abort.
module tb_spi_byte_engine;
  logic clk = 1'b0;
  logic res;

  spi_byte_engine_if bus();

  spi_byte_engine #(.DIV_RESET(8'd59)) dut (
    .mhz48_i(clk),
    .res_i  (res),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          bcnt = 0, nrise = 0, wbad = 0, run = 0;
  int          exp_half = 1, nrise0 = 0;
  int          b0, r0, w0;
  logic        sclk_prev = 1'b0;
  logic [15:0] mosi_cap = 16'h0000;
  logic [7:0]  miso_byte = 8'hFF;

  // Device model: after k rising SCLK edges of a byte it presents bit 7-k.
  assign bus.miso = miso_byte[3'd7 - 3'(nrise - nrise0)];

  // Bus monitor sampled mid-cycle: busy width, SCLK phase widths, MOSI at each rise.
  always @(negedge clk) begin
    if (bus.busy) begin
      bcnt++;
      if (bus.sclk != sclk_prev) begin
        if (run != exp_half) wbad++;
        run = 1;
        if (bus.sclk) begin
          nrise++;
          mosi_cap = {mosi_cap[14:0], bus.mosi};
        end
      end else begin
        run++;
      end
    end else begin
      run = 0;
    end
    sclk_prev = bus.sclk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    bus.cs   = 1'b1;
    bus.we   = 1'b1;
    bus.addr = a;
    bus.din  = d;
    tick();
    bus.cs   = 1'b0;
    bus.we   = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [7:0] exp);
    bus.cs   = 1'b1;
    bus.we   = 1'b0;
    bus.addr = a;
    #1;
    check(tag, {24'd0, bus.dout}, {24'd0, exp});
    tick();
    bus.cs   = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (bus.busy && n < 10000) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
  endtask

  task automatic mark();
    b0     = bcnt;
    r0     = nrise;
    w0     = wbad;
    nrise0 = nrise;
  endtask

  initial begin
    int n;
    bus.cs   = 1'b0;
    bus.we   = 1'b0;
    bus.addr = 2'd0;
    bus.din  = 8'h00;
    res      = 1'b1;
    repeat (3) tick();
    res = 1'b0;
    tick();

    // Reset state
    check("rst_sclk", {31'd0, bus.sclk}, 32'd0);
    check("rst_mosi", {31'd0, bus.mosi}, 32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    rd_chk("rst_status", 2'd1, 8'h00);
    rd_chk("rst_div",    2'd2, 8'd59);
    rd_chk("rst_rx",     2'd0, 8'hFF);
    rd_chk("rst_rsvd",   2'd3, 8'h00);

    // DIV=0, send A5, device returns 3C
    wr(2'd2, 8'd0);
    rd_chk("div0_rd", 2'd2, 8'h00);
    exp_half  = 1;
    miso_byte = 8'h3C;
    mark();
    wr(2'd0, 8'hA5);
    wait_idle("a5");
    check("a5_busy_w", bcnt - b0, 32'd17);
    check("a5_rises",  nrise - r0, 32'd8);
    check("a5_mosi",   {24'd0, mosi_cap[7:0]}, 32'hA5);
    check("a5_phase",  wbad - w0, 32'd0);
    check("a5_mosi_idle", {31'd0, bus.mosi}, 32'd1);
    rd_chk("a5_status_done", 2'd1, 8'h40);
    rd_chk("a5_rx",          2'd0, 8'h3C);
    rd_chk("a5_status_clr",  2'd1, 8'h00);

    // DIV=3, send FF, DIV write mid-transfer ignored
    wr(2'd2, 8'd3);
    exp_half  = 4;
    miso_byte = 8'h81;
    mark();
    wr(2'd0, 8'hFF);
    repeat (5) tick();
    wr(2'd2, 8'h10);
    rd_chk("ff_div_busy", 2'd2, 8'h03);
    wait_idle("ff");
    check("ff_busy_w", bcnt - b0, 32'd65);
    check("ff_rises",  nrise - r0, 32'd8);
    check("ff_mosi",   {24'd0, mosi_cap[7:0]}, 32'hFF);
    check("ff_phase",  wbad - w0, 32'd0);
    rd_chk("ff_div_after", 2'd2, 8'h03);

    // Writes while busy; DONE still set from the FF byte
    wr(2'd2, 8'd1);
    exp_half  = 2;
    miso_byte = 8'h00;
    mark();
`ifdef SPI_TXBUF_EN
    wr(2'd0, 8'h11);
    wr(2'd0, 8'h22);
    wr(2'd0, 8'h33);
    rd_chk("buf_status", 2'd1, 8'hF0);
    wait_idle("buf");
    check("buf_busy_w", bcnt - b0, 32'd66);
    check("buf_rises",  nrise - r0, 32'd16);
    check("buf_mosi",   {16'd0, mosi_cap}, 32'h1122);
`else
    wr(2'd0, 8'h11);
    wr(2'd0, 8'h22);
    rd_chk("ovr_status", 2'd1, 8'hE0);
    wait_idle("ovr");
    check("ovr_busy_w", bcnt - b0, 32'd33);
    check("ovr_rises",  nrise - r0, 32'd8);
    check("ovr_mosi",   {24'd0, mosi_cap[7:0]}, 32'h11);
    check("ovr_phase",  wbad - w0, 32'd0);
`endif
    rd_chk("ovr_status_after", 2'd1, 8'h60);
    wr(2'd1, 8'h20);
    rd_chk("cmd_clr_ovr",  2'd1, 8'h40);
    wr(2'd1, 8'h40);
    rd_chk("cmd_clr_done", 2'd1, 8'h00);

    // DIV=255 boundary
    wr(2'd2, 8'd255);
    exp_half = 256;
    mark();
    wr(2'd0, 8'h5A);
    wait_idle("d255");
    check("d255_busy_w", bcnt - b0, 32'd4097);
    check("d255_phase",  wbad - w0, 32'd0);

    // Reset at bit 4 of a transfer
    wr(2'd2, 8'd1);
    exp_half = 2;
    mark();
    wr(2'd0, 8'h96);
    n = 0;
    while ((nrise - r0) != 4 && n < 2000) begin
      tick();
      n++;
    end
    check("abort_reached_bit4", nrise - r0, 32'd4);
    res      = 1'b1;
    bus.addr = 2'd1;
    tick();
    check("abort_sclk", {31'd0, bus.sclk}, 32'd0);
    check("abort_mosi", {31'd0, bus.mosi}, 32'd1);
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_status", {24'd0, bus.dout}, 32'h00);
    bus.addr = 2'd2;
    #1;
    check("abort_div", {24'd0, bus.dout}, 32'd59);
    bus.addr = 2'd0;
    #1;
    check("abort_rx", {24'd0, bus.dout}, 32'hFF);
    res = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
